// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer commit controller.
package rob_pkg;
  localparam int ROB_DEPTH = 64;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  dest;
    logic [31:0] data;
  } rob_entry_t;
endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Dispatch, CDB, operand-lookup and ARF-commit signals of the ROB.
interface rob_commit_ctrl_if import rob_pkg::*; #(parameter int TAG_W = ROB_TAG_W);
  logic             flush;
  logic             dp_valid;
  logic [4:0]       dp_dest;
  logic             dp_ready;
  logic [TAG_W-1:0] rob_free_entry;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic [TAG_W-1:0] rd_tag1, rd_tag2;
  logic             rd_done1, rd_done2;
  logic [31:0]      rd_data1, rd_data2;
  logic             arf_write_enable;
  logic [4:0]       arf_write_reg;
  logic [31:0]      arf_write_data;
  logic [TAG_W-1:0] arf_write_tag;

  modport master (
    output flush, dp_valid, dp_dest, cdb_valid, cdb_tag, cdb_data, rd_tag1, rd_tag2,
    input  dp_ready, rob_free_entry, rd_done1, rd_done2, rd_data1, rd_data2,
    input  arf_write_enable, arf_write_reg, arf_write_data, arf_write_tag
  );

  modport slave (
    input  flush, dp_valid, dp_dest, cdb_valid, cdb_tag, cdb_data, rd_tag1, rd_tag2,
    output dp_ready, rob_free_entry, rd_done1, rd_done2, rd_data1, rd_data2,
    output arf_write_enable, arf_write_reg, arf_write_data, arf_write_tag
  );
endinterface

// File: rtl/rob_entry_store.sv
// ROB entry array: allocate, CDB-complete and commit-clear writes; head and two tag reads.
module rob_entry_store import rob_pkg::*; #(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_idx,
  input  logic [4:0]       alloc_dest,
  input  logic             cdb_en,
  input  logic [TAG_W-1:0] cdb_idx,
  input  logic [31:0]      cdb_data,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_idx,
  input  logic [TAG_W-1:0] head_idx,
  output rob_entry_t       head_entry,
  input  logic [TAG_W-1:0] rd_idx1,
  input  logic [TAG_W-1:0] rd_idx2,
  output logic             rd_ok1,
  output logic             rd_ok2,
  output logic [31:0]      rd_val1,
  output logic [31:0]      rd_val2
);
  rob_entry_t mem [DEPTH];

  // Alloc and CDB never hit the same slot: CDB needs a valid entry, alloc takes an invalid one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].valid <= 1'b0;
        mem[i].done  <= 1'b0;
      end
    end else begin
      if (cdb_en && mem[cdb_idx].valid) begin
        mem[cdb_idx].done <= 1'b1;
        mem[cdb_idx].data <= cdb_data;
      end
      if (clr_en) mem[clr_idx].valid <= 1'b0;
      if (alloc_en) begin
        mem[alloc_idx].valid <= 1'b1;
        mem[alloc_idx].done  <= 1'b0;
        mem[alloc_idx].dest  <= alloc_dest;
      end
    end
  end

  assign head_entry = mem[head_idx];
  assign rd_ok1     = mem[rd_idx1].valid && mem[rd_idx1].done;
  assign rd_ok2     = mem[rd_idx2].valid && mem[rd_idx2].done;
  assign rd_val1    = mem[rd_idx1].data;
  assign rd_val2    = mem[rd_idx2].data;
endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order ROB controller: tag allocation, CDB capture, one in-order ARF commit per cycle.
module rob_commit_ctrl import rob_pkg::*; #(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  rob_commit_ctrl_if.slave bus
);
  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] head_q, tail_q;
  logic [TAG_W:0]   count_q;
  logic             alloc, commit;
  rob_entry_t       head_entry;
  logic             rd_ok1, rd_ok2;
  logic [31:0]      rd_val1, rd_val2;
  logic             we_q;
  logic [4:0]       reg_q;
  logic [31:0]      data_q;
  logic [TAG_W-1:0] tag_q;

  assign bus.dp_ready       = (count_q != FULL);
  assign bus.rob_free_entry = tail_q;

  // Commit looks only at registered head state, so a fresh CDB result waits one edge.
  assign alloc  = bus.dp_valid && bus.dp_ready && !bus.flush;
  assign commit = head_entry.valid && head_entry.done && !bus.flush;

  rob_entry_store #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_store (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .alloc_en   (alloc),
    .alloc_idx  (tail_q),
    .alloc_dest (bus.dp_dest),
    .cdb_en     (bus.cdb_valid),
    .cdb_idx    (bus.cdb_tag),
    .cdb_data   (bus.cdb_data),
    .clr_en     (commit),
    .clr_idx    (head_q),
    .head_idx   (head_q),
    .head_entry (head_entry),
    .rd_idx1    (bus.rd_tag1),
    .rd_idx2    (bus.rd_tag2),
    .rd_ok1     (rd_ok1),
    .rd_ok2     (rd_ok2),
    .rd_val1    (rd_val1),
    .rd_val2    (rd_val2)
  );

  // Same-cycle CDB result wins over stored state.
  assign bus.rd_done1 = (bus.cdb_valid && bus.cdb_tag == bus.rd_tag1) || rd_ok1;
  assign bus.rd_data1 = (bus.cdb_valid && bus.cdb_tag == bus.rd_tag1) ? bus.cdb_data : rd_val1;
  assign bus.rd_done2 = (bus.cdb_valid && bus.cdb_tag == bus.rd_tag2) || rd_ok2;
  assign bus.rd_data2 = (bus.cdb_valid && bus.cdb_tag == bus.rd_tag2) ? bus.cdb_data : rd_val2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
      tag_q   <= '0;
    end else if (bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
    end else begin
      if (alloc) tail_q <= tail_q + TAG_W'(1);
      if (commit) begin
        head_q <= head_q + TAG_W'(1);
        reg_q  <= head_entry.dest;
        data_q <= head_entry.data;
        tag_q  <= head_q;
      end
      we_q <= commit && (head_entry.dest != 5'd0);
      case ({alloc, commit})
        2'b10:   count_q <= count_q + (TAG_W+1)'(1);
        2'b01:   count_q <= count_q - (TAG_W+1)'(1);
        default: ;
      endcase
    end
  end

  assign bus.arf_write_enable = we_q;
  assign bus.arf_write_reg    = reg_q;
  assign bus.arf_write_data   = data_q;
  assign bus.arf_write_tag    = tag_q;
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Scenario tasks plus randomized traffic against a queue-based program-order model.
module tb_rob_commit_ctrl;
  import rob_pkg::*;
  localparam int D = ROB_DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_commit_ctrl_if #(.TAG_W(ROB_TAG_W)) bus ();
  rob_commit_ctrl #(.DEPTH(D), .TAG_W(ROB_TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: in-flight tags in program order, plus per-tag bookkeeping.
  int          q[$];
  bit          mv[D];
  bit          md[D];
  logic [4:0]  mdest[D];
  logic [31:0] mdata[D];
  int          mtail;
  bit          e_we;
  logic [4:0]  e_reg;
  logic [31:0] e_data;
  logic [5:0]  e_tag;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < D; i++) begin
      mv[i] = 0; md[i] = 0; mdest[i] = '0; mdata[i] = '0;
    end
    mtail = 0; e_we = 0; e_reg = '0; e_data = '0; e_tag = '0;
  endtask

  task automatic model_step();
    bit          do_commit;
    bit          full;
    int          h;
    logic [4:0]  c_dest;
    logic [31:0] c_data;
    if (bus.flush) begin
      q.delete();
      for (int i = 0; i < D; i++) begin mv[i] = 0; md[i] = 0; end
      mtail = 0; e_we = 0;
      return;
    end
    do_commit = (q.size() > 0) && md[q[0]];
    full = (q.size() == D);
    h = do_commit ? q[0] : 0;
    c_dest = mdest[h];
    c_data = mdata[h];
    if (bus.cdb_valid && mv[bus.cdb_tag]) begin
      md[bus.cdb_tag] = 1; mdata[bus.cdb_tag] = bus.cdb_data;
    end
    if (do_commit) begin
      void'(q.pop_front());
      e_we = (c_dest != 0); e_reg = c_dest; e_data = c_data; e_tag = 6'(h);
      mv[h] = 0; md[h] = 0;
    end else e_we = 0;
    if (bus.dp_valid && !full) begin
      mv[mtail] = 1; md[mtail] = 0; mdest[mtail] = bus.dp_dest;
      q.push_back(mtail);
      mtail = (mtail + 1) % D;
    end
  endtask

  task automatic idle();
    bus.flush = 0; bus.dp_valid = 0; bus.dp_dest = '0;
    bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.rd_tag1 = '0; bus.rd_tag2 = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; idle(); #3;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic dispatch(input logic [4:0] dest);
    bus.dp_valid = 1; bus.dp_dest = dest;
    tick();
    bus.dp_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); #2;
    model_reset();
    n_cmp++; if (bus.arf_write_enable !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%0b want=0", bus.arf_write_enable); end
    n_cmp++; if (bus.arf_write_reg !== 5'd0) begin n_bad++; $display("FAIL reset_reg got=%0d want=0", bus.arf_write_reg); end
    n_cmp++; if (bus.arf_write_data !== 32'd0) begin n_bad++; $display("FAIL reset_data got=%h want=0", bus.arf_write_data); end
    n_cmp++; if (bus.arf_write_tag !== 6'd0) begin n_bad++; $display("FAIL reset_tag got=%0d want=0", bus.arf_write_tag); end
    n_cmp++; if (bus.dp_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%0b want=1", bus.dp_ready); end
    n_cmp++; if (bus.rob_free_entry !== 6'd0) begin n_bad++; $display("FAIL reset_free got=%0d want=0", bus.rob_free_entry); end
    n_cmp++; if (bus.rd_done1 !== 1'b0) begin n_bad++; $display("FAIL reset_rd_done got=%0b want=0", bus.rd_done1); end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_out_of_order();
    logic [5:0]  ctag[3];
    logic [31:0] cdat[3];
    logic [4:0]  w_reg[$];
    logic [31:0] w_data[$];
    logic [5:0]  w_tag[$];
    int          w_cyc[$];
    logic [4:0]  x_reg[3];
    logic [31:0] x_data[3];
    ctag = '{6'd2, 6'd0, 6'd1};
    cdat = '{32'h33, 32'h11, 32'h22};
    x_reg = '{5'd5, 5'd6, 5'd7};
    x_data = '{32'h11, 32'h22, 32'h33};
    do_reset();
    dispatch(5'd5); dispatch(5'd6); dispatch(5'd7);
    for (int i = 0; i < 8; i++) begin
      bus.cdb_valid = (i < 3);
      if (i < 3) begin bus.cdb_tag = ctag[i]; bus.cdb_data = cdat[i]; end
      tick();
      n_cmp++; if (bus.arf_write_enable !== e_we) begin n_bad++; $display("FAIL ooo_we cyc=%0d got=%0b want=%0b", i, bus.arf_write_enable, e_we); end
      if (bus.arf_write_enable === 1'b1) begin
        w_reg.push_back(bus.arf_write_reg); w_data.push_back(bus.arf_write_data);
        w_tag.push_back(bus.arf_write_tag); w_cyc.push_back(i);
      end
    end
    bus.cdb_valid = 0;
    n_cmp++; if (w_reg.size() != 3) begin n_bad++; $display("FAIL ooo_count got=%0d want=3", w_reg.size()); end
    for (int k = 0; k < 3 && k < w_reg.size(); k++) begin
      n_cmp++;
      if (w_reg[k] !== x_reg[k] || w_data[k] !== x_data[k] || w_tag[k] !== 6'(k))
        begin n_bad++; $display("FAIL ooo_write%0d got=x%0d/%h/t%0d want=x%0d/%h/t%0d", k, w_reg[k], w_data[k], w_tag[k], x_reg[k], x_data[k], k); end
      if (k > 0) begin
        n_cmp++; if (w_cyc[k] != w_cyc[k-1] + 1) begin n_bad++; $display("FAIL ooo_consecutive k=%0d got=%0d want=%0d", k, w_cyc[k], w_cyc[k-1] + 1); end
      end
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    bus.dp_valid = 1;
    for (int i = 0; i < D; i++) begin bus.dp_dest = 5'((i % 31) + 1); tick(); end
    n_cmp++; if (bus.dp_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%0b want=0", bus.dp_ready); end
    n_cmp++; if (bus.rob_free_entry !== 6'd0) begin n_bad++; $display("FAIL full_free got=%0d want=0", bus.rob_free_entry); end
    bus.dp_dest = 5'd9;
    tick();
    n_cmp++; if (bus.rob_free_entry !== 6'd0 || bus.dp_ready !== 1'b0) begin n_bad++; $display("FAIL full_blocked got=free%0d/rdy%0b want=free0/rdy0", bus.rob_free_entry, bus.dp_ready); end
    bus.cdb_valid = 1; bus.cdb_tag = 6'd0; bus.cdb_data = 32'hA5A5;
    tick();
    bus.cdb_valid = 0;
    n_cmp++; if (bus.dp_ready !== 1'b0) begin n_bad++; $display("FAIL full_done_ready got=%0b want=0", bus.dp_ready); end
    tick();
    n_cmp++; if (bus.dp_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_ready got=%0b want=1", bus.dp_ready); end
    n_cmp++; if (bus.rob_free_entry !== 6'd0) begin n_bad++; $display("FAIL wrap_free got=%0d want=0", bus.rob_free_entry); end
    n_cmp++; if (bus.arf_write_enable !== 1'b1 || bus.arf_write_tag !== 6'd0 || bus.arf_write_reg !== 5'd1 || bus.arf_write_data !== 32'hA5A5)
      begin n_bad++; $display("FAIL wrap_commit got=%0b/t%0d/x%0d/%h want=1/t0/x1/a5a5", bus.arf_write_enable, bus.arf_write_tag, bus.arf_write_reg, bus.arf_write_data); end
    tick();
    bus.dp_valid = 0;
    n_cmp++; if (bus.rob_free_entry !== 6'd1 || bus.dp_ready !== 1'b0) begin n_bad++; $display("FAIL wrap_realloc got=free%0d/rdy%0b want=free1/rdy0", bus.rob_free_entry, bus.dp_ready); end
  endtask

  task automatic test_x0();
    do_reset();
    dispatch(5'd0); dispatch(5'd9);
    bus.cdb_valid = 1; bus.cdb_tag = 6'd0; bus.cdb_data = 32'h77;
    tick();
    bus.cdb_valid = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (bus.arf_write_enable !== 1'b0) begin n_bad++; $display("FAIL x0_silent cyc=%0d got=%0b want=0", i, bus.arf_write_enable); end
    end
    bus.cdb_valid = 1; bus.cdb_tag = 6'd1; bus.cdb_data = 32'h99;
    tick();
    bus.cdb_valid = 0;
    n_cmp++; if (bus.arf_write_enable !== 1'b0) begin n_bad++; $display("FAIL x0_early got=%0b want=0", bus.arf_write_enable); end
    tick();
    n_cmp++; if (bus.arf_write_enable !== 1'b1 || bus.arf_write_tag !== 6'd1 || bus.arf_write_reg !== 5'd9 || bus.arf_write_data !== 32'h99)
      begin n_bad++; $display("FAIL x0_next got=%0b/t%0d/x%0d/%h want=1/t1/x9/99", bus.arf_write_enable, bus.arf_write_tag, bus.arf_write_reg, bus.arf_write_data); end
    n_cmp++; if (bus.rob_free_entry !== 6'd2 || bus.dp_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ptrs got=free%0d/rdy%0b want=free2/rdy1", bus.rob_free_entry, bus.dp_ready); end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 1; i <= 4; i++) dispatch(5'(i));
    bus.rd_tag1 = 6'd3; bus.rd_tag2 = 6'd2;
    bus.cdb_valid = 1; bus.cdb_tag = 6'd3; bus.cdb_data = 32'hDEAD;
    #1;
    n_cmp++; if (bus.rd_done1 !== 1'b1 || bus.rd_data1 !== 32'hDEAD) begin n_bad++; $display("FAIL bypass got=%0b/%h want=1/dead", bus.rd_done1, bus.rd_data1); end
    n_cmp++; if (bus.rd_done2 !== 1'b0) begin n_bad++; $display("FAIL bypass_other got=%0b want=0", bus.rd_done2); end
    tick();
    bus.cdb_valid = 0;
    #1;
    n_cmp++; if (bus.rd_done1 !== 1'b1 || bus.rd_data1 !== 32'hDEAD) begin n_bad++; $display("FAIL stored got=%0b/%h want=1/dead", bus.rd_done1, bus.rd_data1); end
    bus.rd_tag1 = 6'd5;
    #1;
    n_cmp++; if (bus.rd_done1 !== 1'b0) begin n_bad++; $display("FAIL rd_invalid got=%0b want=0", bus.rd_done1); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 5; i++) dispatch(5'(i));
    bus.cdb_valid = 1; bus.cdb_tag = 6'd1; bus.cdb_data = 32'h1;
    tick();
    bus.cdb_tag = 6'd3; bus.cdb_data = 32'h3;
    tick();
    bus.flush = 1; bus.dp_valid = 1; bus.dp_dest = 5'd7;
    bus.cdb_tag = 6'd0; bus.cdb_data = 32'h55;
    tick();
    idle();
    bus.rd_tag1 = 6'd1; bus.rd_tag2 = 6'd3;
    #1;
    n_cmp++; if (bus.rob_free_entry !== 6'd0 || bus.dp_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ptrs got=free%0d/rdy%0b want=free0/rdy1", bus.rob_free_entry, bus.dp_ready); end
    n_cmp++; if (bus.arf_write_enable !== 1'b0) begin n_bad++; $display("FAIL flush_we got=%0b want=0", bus.arf_write_enable); end
    n_cmp++; if (bus.rd_done1 !== 1'b0 || bus.rd_done2 !== 1'b0) begin n_bad++; $display("FAIL flush_done got=%0b%0b want=00", bus.rd_done1, bus.rd_done2); end
    tick(); tick();
    n_cmp++; if (bus.arf_write_enable !== 1'b0) begin n_bad++; $display("FAIL flush_quiet got=%0b want=0", bus.arf_write_enable); end
  endtask

  task automatic test_reset_mid_commit();
    do_reset();
    dispatch(5'd3);
    bus.cdb_valid = 1; bus.cdb_tag = 6'd0; bus.cdb_data = 32'h42;
    tick();
    bus.cdb_valid = 0;
    tick();
    n_cmp++; if (bus.arf_write_enable !== 1'b1) begin n_bad++; $display("FAIL pre_rst_we got=%0b want=1", bus.arf_write_enable); end
    #1 rst = 1;
    #1;
    model_reset();
    n_cmp++; if (bus.arf_write_enable !== 1'b0) begin n_bad++; $display("FAIL async_rst_we got=%0b want=0", bus.arf_write_enable); end
    n_cmp++; if (bus.rob_free_entry !== 6'd0 || bus.dp_ready !== 1'b1 || bus.arf_write_tag !== 6'd0)
      begin n_bad++; $display("FAIL async_rst_ptrs got=free%0d/rdy%0b/t%0d want=0/1/0", bus.rob_free_entry, bus.dp_ready, bus.arf_write_tag); end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_random();
    bit          xd1, xd2;
    logic [31:0] xv1, xv2;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int cdb_pct;
      cdb_pct = ((i / 400) % 2 == 0) ? 10 : 75;
      bus.flush = ($urandom_range(0, 199) == 0);
      bus.dp_valid = ($urandom_range(0, 3) != 0);
      bus.dp_dest = 5'($urandom_range(0, 31));
      bus.cdb_valid = ($urandom_range(0, 99) < cdb_pct);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) bus.cdb_tag = 6'(q[$urandom_range(0, q.size() - 1)]);
      else bus.cdb_tag = 6'($urandom_range(0, D - 1));
      bus.cdb_data = $urandom;
      bus.rd_tag1 = ($urandom_range(0, 3) == 0) ? bus.cdb_tag : 6'($urandom_range(0, D - 1));
      bus.rd_tag2 = 6'($urandom_range(0, D - 1));
      #1;
      xd1 = (bus.cdb_valid && bus.cdb_tag == bus.rd_tag1) || (mv[bus.rd_tag1] && md[bus.rd_tag1]);
      xv1 = (bus.cdb_valid && bus.cdb_tag == bus.rd_tag1) ? bus.cdb_data : mdata[bus.rd_tag1];
      xd2 = (bus.cdb_valid && bus.cdb_tag == bus.rd_tag2) || (mv[bus.rd_tag2] && md[bus.rd_tag2]);
      xv2 = (bus.cdb_valid && bus.cdb_tag == bus.rd_tag2) ? bus.cdb_data : mdata[bus.rd_tag2];
      n_cmp++; if (bus.dp_ready !== (q.size() != D)) begin n_bad++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", i, bus.dp_ready, q.size() != D); end
      n_cmp++; if (bus.rob_free_entry !== 6'(mtail)) begin n_bad++; $display("FAIL rnd_free cyc=%0d got=%0d want=%0d", i, bus.rob_free_entry, mtail); end
      n_cmp++; if (bus.rd_done1 !== xd1 || (xd1 && bus.rd_data1 !== xv1)) begin n_bad++; $display("FAIL rnd_rd1 cyc=%0d got=%0b/%h want=%0b/%h", i, bus.rd_done1, bus.rd_data1, xd1, xv1); end
      n_cmp++; if (bus.rd_done2 !== xd2 || (xd2 && bus.rd_data2 !== xv2)) begin n_bad++; $display("FAIL rnd_rd2 cyc=%0d got=%0b/%h want=%0b/%h", i, bus.rd_done2, bus.rd_data2, xd2, xv2); end
      tick();
      n_cmp++;
      if (bus.arf_write_enable !== e_we || bus.arf_write_reg !== e_reg || bus.arf_write_data !== e_data || bus.arf_write_tag !== e_tag)
        begin n_bad++; $display("FAIL rnd_arf cyc=%0d got=%0b/x%0d/%h/t%0d want=%0b/x%0d/%h/t%0d", i, bus.arf_write_enable, bus.arf_write_reg, bus.arf_write_data, bus.arf_write_tag, e_we, e_reg, e_data, e_tag); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_out_of_order();
    test_full_wrap();
    test_x0();
    test_bypass();
    test_flush();
    test_reset_mid_commit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- In-order reorder-buffer controller that owns all ARF writeback sequencing.
- At dispatch it allocates a tag, which is the ROB index driven to the ARF as rob_free_entry.
- It captures results from the common data bus (CDB) and retires completed entries strictly in program order, one per cycle, through the ARF write port.
- It provides two tag-indexed read ports so dispatch can fetch values for busy ARF sources.

Parameters:
- DEPTH, 64, number of ROB entries; must be a power of two.
- TAG_W, 6, tag width; equals log2(DEPTH), matches the ARF tag field.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  discard all in-flight entries
- dp_valid  in  1  dispatch requests an allocation
- dp_dest  in  5  destination architectural register of the dispatching instruction
- dp_ready  out  1  ROB can accept an allocation this cycle
- rob_free_entry  out  TAG_W  tag that the next allocation will receive
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_W  tag of the broadcast result
- cdb_data  in  32  broadcast result value
- rd_tag1, rd_tag2  in  TAG_W  operand lookup tags
- rd_done1, rd_done2  out  1  looked-up entry has its result
- rd_data1, rd_data2  out  32  looked-up entry's value
- arf_write_enable  out  1  commit write strobe to the ARF
- arf_write_reg  out  5  committed destination register
- arf_write_data  out  32  committed value
- arf_write_tag  out  TAG_W  tag of the committing entry, for a later ARF tag-match busy clear

Behaviour:
- State:
  - head and tail pointers, each TAG_W bits, wrapping modulo DEPTH.
  - count, TAG_W+1 bits.
  - Per entry: valid, done, dest[4:0], data[31:0].
- Reset, asserted asynchronously:
  - head, tail and count are 0; every valid and done bit is 0.
  - All arf_* outputs are 0; dp_ready=1; rob_free_entry=0.
- Combinational outputs:
  - dp_ready = (count != DEPTH).
  - rob_free_entry = tail.
- Allocate, when dp_valid && dp_ready at the clock edge:
  - entry[tail] gets valid=1, done=0, dest=dp_dest.
  - tail increments.
  - x0 destinations still allocate an entry.
- A dp_valid seen while full is ignored; there is no same-cycle reuse of the slot freed by a commit.
- Completion, when cdb_valid at the clock edge:
  - If entry[cdb_tag].valid, set done=1 and data=cdb_data.
  - A CDB write to an invalid entry is ignored.
  - A CDB write to an already-done entry overwrites data.
- Commit decision:
  - Made on registered state: if entry[head].valid && entry[head].done, then at the edge entry[head].valid is cleared and head increments.
  - The arf_* outputs are registered from that entry's dest, data and tag.
  - arf_write_enable = (dest != 0). An x0 entry retires silently.
  - Without a commit, arf_write_enable is 0 next cycle; arf_write_reg, arf_write_data and arf_write_tag hold their previous values.
- Latency:
  - CDB at edge N sets done.
  - If that entry is head, the commit edge is N+1 and arf_write_enable is high in the cycle after N+1.
  - The ARF captures the write at edge N+2.
  - Maximum throughput is one commit per cycle.
- Count update:
  - +1 on allocate only, −1 on commit only, unchanged when both happen.
  - Allocation into an empty ROB cannot commit in the same cycle.
- Read ports are combinational:
  - If cdb_valid && cdb_tag==rd_tagX: done=1, data=cdb_data (CDB bypass).
  - Otherwise: done = entry.valid && entry.done, data = entry.data.
- Flush, synchronous with highest priority:
  - Next cycle head=tail=count=0, all valid and done bits are clear, arf_write_enable=0.
  - Allocation, completion and commit in the flush cycle are discarded.
- Wrap-around: pointers roll from DEPTH-1 to 0; full and empty are distinguished only by count.

Decomposition:
- Package rob_pkg holds:
  - ROB_DEPTH and ROB_TAG_W constants.
  - Typedef rob_tag_t.
  - Struct rob_entry_t {valid, done, dest, data}.
- Sub-module rob_entry_store: a DEPTH-entry array with
  - one allocate write port,
  - one CDB write port,
  - a head read port,
  - two tag read ports.
- The pointer, count and commit logic stays in rob_commit_ctrl.

Test Plan:
- Out-of-order completion:
  - Stimulus: reset; dispatch dest x5, x6, x7 (tags 0, 1, 2); CDB tag2=0x33, then tag0=0x11, then tag1=0x22.
  - Response: ARF writes occur in order x5=0x11, x6=0x22, x7=0x33 on consecutive cycles, with arf_write_tag 0, 1, 2.
- Full and wrap:
  - Stimulus: dispatch 64 entries without completing any; then complete and commit tag0 while dp_valid is held.
  - Response: dp_ready=0 at count=64 and allocation is blocked; after the commit, dp_ready=1 and the next allocation gets rob_free_entry=0 with tail wrapped.
- x0 destination:
  - Stimulus: dispatch dest x0, complete it.
  - Response: head advances and count decrements, but arf_write_enable stays 0.
- Read-port bypass:
  - Stimulus: rd_tag1=3 while cdb_valid with tag3=0xDEAD.
  - Response: rd_done1=1, rd_data1=0xDEAD in the same cycle.
  - Follow-up: the next cycle, with no CDB, returns the stored value.
- Flush mid-operation:
  - Stimulus: 5 entries in flight with 2 done; assert flush together with dp_valid and cdb_valid.
  - Response: count=0 next cycle, no ARF write, rob_free_entry=0.
- Reset mid-commit:
  - Stimulus: assert rst asynchronously while arf_write_enable=1.
  - Response: arf_write_enable drops immediately; all pointers read 0.
